// File: rtl/mul_result_stage.sv
// mul_result_stage: result stage behind the 32x32 signed tree multiplier.
// It selects the low or high product word, or accumulates the product into a
// 64-bit accumulator. Results are queued in a small valid/ready output FIFO.
// Optional build macro: SATURATE_EN. When it is defined, a MAC overflow
// clamps the accumulator instead of letting it wrap.
module mul_result_stage #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_product,
  input  logic [1:0]  in_op,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_ovf,
  output logic [63:0] acc_q,
  output logic        ovf_sticky
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    OP_LO  = 2'b00,
    OP_HI  = 2'b01,
    OP_MAC = 2'b10,
    OP_CLR = 2'b11
  } op_e;

  typedef struct packed {
    logic [31:0] data;
    logic        ovf;
  } entry_t;

  entry_t         mem [DEPTH];
  logic [AW-1:0]  rd_ptr, wr_ptr;
  logic [CW-1:0]  count;

  logic           in_fire, out_fire, push;
  logic [63:0]    sum, mac_res;
  logic           mac_ovf;
  entry_t         push_entry;

  // Handshakes. Room is judged on the registered count only, so a pop in the
  // same cycle never frees a slot for a push while full.
  assign in_ready  = (count != CW'(DEPTH));
  assign out_valid = (count != '0);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign push      = in_fire && (in_op != OP_CLR);

  // Head entry drives the outputs; an empty FIFO reads as zero.
  assign out_data  = out_valid ? mem[rd_ptr].data : '0;
  assign out_ovf   = out_valid ? mem[rd_ptr].ovf  : 1'b0;

  // MAC datapath and selection of the word to enqueue.
  always_comb begin
    sum     = acc_q + in_product;
    mac_ovf = (acc_q[63] == in_product[63]) && (sum[63] != acc_q[63]);
`ifdef SATURATE_EN
    // Overflow direction follows the shared operand sign.
    if (mac_ovf) mac_res = acc_q[63] ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF;
    else         mac_res = sum;
`else
    mac_res = sum;
`endif
    push_entry = '0;
    case (in_op)
      OP_LO:   push_entry = '{data: in_product[31:0],  ovf: 1'b0};
      OP_HI:   push_entry = '{data: in_product[63:32], ovf: 1'b0};
      OP_MAC:  push_entry = '{data: mac_res[31:0],     ovf: mac_ovf};
      default: push_entry = '0;
    endcase
  end

  // Accumulator and sticky overflow; only accepted MAC/ACC_CLR touch them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q      <= '0;
      ovf_sticky <= 1'b0;
    end else if (in_fire) begin
      if (in_op == OP_MAC) begin
        acc_q      <= mac_res;
        ovf_sticky <= ovf_sticky | mac_ovf;
      end else if (in_op == OP_CLR) begin
        acc_q      <= '0;
        ovf_sticky <= 1'b0;
      end
    end
  end

  // Output FIFO storage, pointers (wrap naturally, DEPTH is a power of two)
  // and occupancy count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (out_fire) rd_ptr <= rd_ptr + AW'(1);
      case ({push, out_fire})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_result_stage.sv
// tb_mul_result_stage: scoreboard bench for mul_result_stage. A negedge
// reference model tracks the accumulator with 65-bit arithmetic and queues
// expected output words on every accept. A separate monitor pops and compares
// on every DUT pop. Directed scenarios are followed by a randomized phase.
module tb_mul_result_stage;

  localparam int DEPTH = 2;
  localparam logic signed [64:0] MAXV = 65'sh0_7FFF_FFFF_FFFF_FFFF;
  localparam logic signed [64:0] MINV = 65'sh1_8000_0000_0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_product = '0;
  logic [1:0]  in_op = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_ovf;
  logic [63:0] acc_q;
  logic        ovf_sticky;

  mul_result_stage #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_product(in_product), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ovf(out_ovf),
    .acc_q(acc_q), .ovf_sticky(ovf_sticky)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic        o;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] m_acc = '0;
  logic        m_st = 1'b0;
  int          n_tests = 0;
  int          n_fail = 0;
  logic        rnd_rdy = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: check the visible state, then apply any accept.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_acc = '0;
      m_st  = 1'b0;
      exp_q.delete();
    end else begin
      chk("acc_q", acc_q, m_acc);
      chk("ovf_sticky", {63'b0, ovf_sticky}, {63'b0, m_st});
      chk("in_ready", {63'b0, in_ready}, {63'b0, exp_q.size() < DEPTH});
      chk("out_valid", {63'b0, out_valid}, {63'b0, exp_q.size() != 0});
      if (exp_q.size() == 0) chk("empty_out_data", {32'b0, out_data}, 64'd0);
      if (in_valid && in_ready) begin
        logic signed [64:0] wide;
        logic [63:0] res;
        logic ov;
        case (in_op)
          2'b00: exp_q.push_back('{d: in_product[31:0],  o: 1'b0});
          2'b01: exp_q.push_back('{d: in_product[63:32], o: 1'b0});
          2'b10: begin
            wide = $signed({m_acc[63], m_acc}) + $signed({in_product[63], in_product});
            ov   = (wide > MAXV) || (wide < MINV);
`ifdef SATURATE_EN
            if (wide > MAXV)      res = 64'h7FFF_FFFF_FFFF_FFFF;
            else if (wide < MINV) res = 64'h8000_0000_0000_0000;
            else                  res = wide[63:0];
`else
            res = wide[63:0];
`endif
            m_acc = res;
            m_st  = m_st || ov;
            exp_q.push_back('{d: res[31:0], o: ov});
          end
          default: begin
            m_acc = '0;
            m_st  = 1'b0;
          end
        endcase
      end
    end
  end

  // Monitor: compares each popped head entry against the scoreboard.
  always @(negedge clk) begin
    #1;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_pop: got %h expected no entry", out_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("out_data", {32'b0, out_data}, {32'b0, e.d});
        chk("out_ovf", {63'b0, out_ovf}, {63'b0, e.o});
      end
    end
  end

  // Random downstream backpressure during the randomized phase.
  always @(posedge clk) begin
    if (rnd_rdy) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Drive one op from posedge+1 until accepted; returns at posedge+1.
  task automatic send(input logic [1:0] op, input logic [63:0] prod);
    int waited;
    in_valid   = 1'b1;
    in_op      = op;
    in_product = prod;
    waited     = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!in_ready && waited < 500);
    if (!in_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: got no accept expected accept within 500 cycles");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < 200) begin
      @(posedge clk);
      c++;
    end
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] rnd_prod();
    logic [63:0] p;
    case ($urandom_range(0, 3))
      0: p = {$urandom, $urandom};
      1: p = 64'($signed($urandom_range(0, 2000)) - 1000);
      2: p = {1'b0, 31'($urandom), $urandom};
      default: p = {1'b1, 31'($urandom), $urandom};
    endcase
    return p;
  endfunction

  initial begin
    int held;
    // Reset values while rst_n is low.
    #12;
    chk("rst_acc", acc_q, 64'd0);
    chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_out_data", {32'b0, out_data}, 64'd0);
    chk("rst_out_ovf", {63'b0, out_ovf}, 64'd0);
    chk("rst_in_ready", {63'b0, in_ready}, 64'd1);
    chk("rst_sticky", {63'b0, ovf_sticky}, 64'd0);
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // MUL_LO / MUL_HI of -2*5.
    out_ready = 1'b1;
    send(2'b00, 64'hFFFF_FFFF_FFFF_FFF6);
    send(2'b01, 64'hFFFF_FFFF_FFFF_FFF6);
    wait_drain();

    // MAC chain 100, 200, -50.
    send(2'b11, 64'd0);
    send(2'b10, 64'd100);
    @(negedge clk); chk("mac_acc_100", acc_q, 64'd100);
    @(posedge clk); #1;
    send(2'b10, 64'd200);
    send(2'b10, -64'sd50);
    @(negedge clk); chk("mac_acc_250", acc_q, 64'd250);
    @(posedge clk); #1;
    wait_drain();

    // Positive overflow.
    send(2'b11, 64'd0);
    send(2'b10, 64'h7FFF_FFFF_FFFF_FFFF);
    send(2'b10, 64'd1);
    @(negedge clk);
`ifdef SATURATE_EN
    chk("ovf_acc", acc_q, 64'h7FFF_FFFF_FFFF_FFFF);
`else
    chk("ovf_acc", acc_q, 64'h8000_0000_0000_0000);
`endif
    chk("ovf_sticky_set", {63'b0, ovf_sticky}, 64'd1);
    @(posedge clk); #1;
    wait_drain();
    send(2'b11, 64'd0);
    @(negedge clk); chk("ovf_sticky_clr", {63'b0, ovf_sticky}, 64'd0);
    @(posedge clk); #1;

    // Backpressure: two fill the FIFO, the third waits for out_ready.
    out_ready = 1'b0;
    send(2'b00, 64'd1);
    send(2'b00, 64'd2);
    in_valid = 1'b1; in_op = 2'b00; in_product = 64'd3;
    held = 0;
    repeat (4) begin
      @(negedge clk);
      if (in_ready) held++;
    end
    chk("bp_held_off", 64'(held), 64'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(2'b00, 64'd3);
    wait_drain();

    // Push and pop together at count 1.
    out_ready = 1'b0;
    send(2'b00, 64'd10);
    out_ready = 1'b1;
    send(2'b00, 64'd11);
    send(2'b00, 64'd12);
    send(2'b00, 64'd13);
    wait_drain();

    // Reset mid-stream with two queued entries and acc = 300.
    out_ready = 1'b0;
    send(2'b11, 64'd0);
    send(2'b10, 64'd100);
    send(2'b10, 64'd200);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("midrst_acc", acc_q, 64'd0);
    chk("midrst_in_ready", {63'b0, in_ready}, 64'd1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("midrst_no_pop", {63'b0, out_valid}, 64'd0);
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Randomized ops with random backpressure and idle gaps.
    rnd_rdy = 1'b1;
    for (int i = 0; i < 400; i++) begin
      logic [1:0] op;
      op = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'(($urandom_range(0, 5) < 3) ? 2 : $urandom_range(0, 1));
      send(op, rnd_prod());
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end
    rnd_rdy = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
